// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative radix-2 multiply/divide unit with architectural HI/LO registers
// Optional feature: define MULDIV_MADD_EN to enable MADD/MADDU (op 100/101) accumulate into {hi,lo}.
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   start, op      launch MULT/MULTU/DIV/DIVU(/MADD/MADDU) when not busy
//   a, b           operands, sampled when start is accepted
//   wr_hi, wr_lo   MTHI/MTLO writes of wdata, honoured when not busy
//   busy, done     handshake: busy for WIDTH cycles, then a one-cycle done
//   dbz            divide-by-zero flag, valid with done, held until next accepted start
//   hi, lo         HI/LO registers
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] r, q, m, r_n, q_n, am, bm, quo, rem, sub;
  logic [2:0] op_r;
  logic pneg, rneg, op_ok, accept, is_div, div_r, sgn, last, ge;
  logic [WIDTH:0] msum;
  logic [2*WIDTH-1:0] prod, prod_s, mres;
`ifdef MULDIV_MADD_EN
  assign op_ok = op <= 3'd5;
  assign mres = op_r[2] ? {hi, lo} + prod_s : prod_s;
`else
  assign op_ok = !op[2];
  assign mres = prod_s;
`endif
  assign busy = state == RUN;
  assign done = state == FIN;
  assign accept = start && !busy && op_ok;
  assign is_div = op[2:1] == 2'b01;
  assign div_r = op_r[2:1] == 2'b01;
  assign sgn = !op[0];
  assign am = (sgn && a[WIDTH-1]) ? -a : a;
  assign bm = (sgn && b[WIDTH-1]) ? -b : b;
  assign last = busy && cnt == CNT_W'(WIDTH - 1);
  // multiply: shift-add on {r,q}, q holds the multiplier and collects product low bits
  assign msum = {1'b0, r} + (q[0] ? {1'b0, m} : '0);
  // divide: restoring step on the partial remainder r with dividend bits shifted out of q
  assign ge = {r, q[WIDTH-1]} >= {1'b0, m};
  assign sub = {r[WIDTH-2:0], q[WIDTH-1]} - m;
  assign r_n = div_r ? (ge ? sub : {r[WIDTH-2:0], q[WIDTH-1]}) : msum[WIDTH:1];
  assign q_n = div_r ? {q[WIDTH-2:0], ge} : {msum[0], q[WIDTH-1:1]};
  assign prod = {r_n, q_n};
  assign prod_s = pneg ? -prod : prod;
  // a zero divisor yields remainder = a naturally; only the quotient needs forcing
  assign quo = dbz ? '1 : (pneg ? -q_n : q_n);
  assign rem = rneg ? -r_n : r_n;
  always_comb begin
    state_n = busy ? (last ? FIN : RUN) : (accept ? RUN : IDLE);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      op_r <= '0;
      pneg <= 1'b0;
      rneg <= 1'b0;
      dbz <= 1'b0;
      r <= '0;
      q <= '0;
      m <= '0;
      hi <= '0;
      lo <= '0;
    end else begin
      if (accept) begin
        cnt <= '0;
        op_r <= op;
        pneg <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
        rneg <= sgn && a[WIDTH-1];
        dbz <= is_div && b == '0;
        r <= '0;
        m <= is_div ? bm : am;
        q <= is_div ? am : bm;
      end else if (busy) begin
        r <= r_n;
        q <= q_n;
        cnt <= cnt + CNT_W'(1);
      end
      if (last) begin
        hi <= div_r ? rem : mres[2*WIDTH-1:WIDTH];
        lo <= div_r ? quo : mres[WIDTH-1:0];
      end else begin
        if (wr_hi && !busy) hi <= wdata;
        if (wr_lo && !busy) lo <= wdata;
      end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: randomized self-checking bench for mul_div_unit against an arithmetic model
module tb_mul_div_unit;
  localparam int W = 32;
  logic clk = 0, reset = 0, start = 0, wr_hi = 0, wr_lo = 0;
  logic [2:0] op = 0;
  logic [W-1:0] a = 0, b = 0, wdata = 0;
  logic busy, done, dbz;
  logic [W-1:0] hi, lo;
  logic [W-1:0] mhi = 0, mlo = 0;
  logic mdbz = 0;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .busy(busy), .done(done), .dbz(dbz), .hi(hi), .lo(lo)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic bit op_valid(input logic [2:0] o);
`ifdef MULDIV_MADD_EN
    return o <= 3'd5;
`else
    return o <= 3'd3;
`endif
  endfunction
  task automatic model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p = 64'(sx * sy);
    if (o[0]) p = {32'b0, x} * {32'b0, y};
    if (o[2]) p = {mhi, mlo} + p;
    mdbz = 0;
    if (o == 3'd2 || o == 3'd3) begin
      if (y == 0) begin
        mdbz = 1;
        mhi = x;
        mlo = '1;
      end else if (o == 3'd2 && x == 32'h80000000 && y == 32'hFFFFFFFF) begin
        mlo = x;
        mhi = 0;
      end else if (o == 3'd2) begin
        mlo = W'(sx / sy);
        mhi = W'(sx % sy);
      end else begin
        mlo = x / y;
        mhi = x % y;
      end
    end else {mhi, mlo} = p;
  endtask
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit wh, input bit wl, input logic [W-1:0] wd, input string tag);
    int n;
    op = o; a = x; b = y; start = 1; wr_hi = wh; wr_lo = wl; wdata = wd;
    @(posedge clk); #1;
    start = 0; wr_hi = 0; wr_lo = 0;
    if (wh) mhi = wd;
    if (wl) mlo = wd;
    if (!op_valid(o)) begin
      check({tag, " rsv busy"}, busy, 0);
      check({tag, " rsv hilo"}, {hi, lo}, {mhi, mlo});
      check({tag, " rsv dbz"}, dbz, mdbz);
      return;
    end
    model(o, x, y);
    check({tag, " busy"}, busy, 1);
    n = 1;
    while (!done && n < W + 5) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, n, W + 1);
    check({tag, " busy@done"}, busy, 0);
    check({tag, " hi"}, hi, mhi);
    check({tag, " lo"}, lo, mlo);
    check({tag, " dbz"}, dbz, mdbz);
  endtask
  task automatic mtx(input bit h, input logic [W-1:0] wd);
    wr_hi = h; wr_lo = !h; wdata = wd;
    @(posedge clk); #1;
    wr_hi = 0; wr_lo = 0;
    if (h) mhi = wd;
    else mlo = wd;
    check(h ? "mthi" : "mtlo", h ? hi : lo, wd);
  endtask
  initial begin
    logic [2:0] o;
    logic [W-1:0] x, y;
    int seen;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst dbz", dbz, 0);
    check("rst hilo", {hi, lo}, 0);
    reset = 1;
    @(posedge clk); #1;
    issue(3'd0, 32'hFFFFFFFD, 32'h7, 0, 0, 0, "t1");
    check("t1 hi const", hi, 32'hFFFFFFFF);
    check("t1 lo const", lo, 32'hFFFFFFEB);
    @(posedge clk); #1;
    check("done pulse", done, 0);
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, "t2");
    check("t2 hi const", hi, 32'hFFFFFFFE);
    check("t2 lo const", lo, 32'h1);
    issue(3'd2, 32'hFFFFFFF9, 32'h2, 0, 0, 0, "t3a");
    check("t3a lo const", lo, 32'hFFFFFFFD);
    check("t3a hi const", hi, 32'hFFFFFFFF);
    issue(3'd3, 32'h7, 32'h2, 0, 0, 0, "t3b");
    issue(3'd3, 32'h1234, 32'h0, 0, 0, 0, "t4");
    check("t4 dbz const", dbz, 1);
    check("t4 lo const", lo, 32'hFFFFFFFF);
    check("t4 hi const", hi, 32'h1234);
    issue(3'd7, 32'h5, 32'h6, 1, 0, 32'h12345678, "rsv7");
    issue(3'd0, 32'h3, 32'h5, 0, 0, 0, "t4b");
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, "minneg");
    issue(3'd2, 32'h80000000, 32'h0, 0, 0, 0, "sdbz");
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 7) == 0) y = 0;
      if ($urandom_range(0, 7) == 0) x = 32'h80000000;
      if ($urandom_range(0, 7) == 0) y = 32'hFFFFFFFF;
      if ($urandom_range(0, 3) == 0) y = W'($urandom_range(1, 20));
      issue(o, x, y, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom, $sformatf("r%0d", i));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        check("gap done", done, 0);
      end
    end
    mtx(1, 32'h0);
    mtx(0, 32'hFFFFFFFF);
    issue(3'd5, 32'h1, 32'h1, 0, 0, 0, "t6");
    issue(3'd4, 32'hFFFFFFFF, 32'h3, 0, 0, 0, "t6s");
    op = 3'd0; a = $urandom; b = $urandom; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (4) @(posedge clk);
    #1;
    op = 3'd3; start = 1; wr_hi = 1; wdata = 32'hAAAA5555;
    @(posedge clk); #1;
    start = 0; wr_hi = 0;
    check("t5 busy", busy, 1);
    check("t5 hi kept", hi, mhi);
    repeat (4) @(posedge clk);
    #1;
    reset = 0;
    #1;
    check("t5 rst busy", busy, 0);
    check("t5 rst hilo", {hi, lo}, 0);
    check("t5 rst dbz", dbz, 0);
    @(posedge clk); #1;
    reset = 1;
    seen = 0;
    repeat (W + 5) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1;
    end
    check("t5 no done", seen, 0);
    mhi = 0; mlo = 0; mdbz = 0;
    issue(3'd1, 32'hDEADBEEF, 32'h12345, 0, 1, 32'h5A5A5A5A, "post");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
